// File: rtl/lfsr_encryptor.sv
// Frames a plaintext message as preamble / message / padding, XORs each byte with a 6-bit
// maximal-length LFSR keystream and writes the 64-byte ciphertext frame to external memory.
module lfsr_encryptor #(
    parameter int         PRE_LEN   = 7,
    parameter logic [7:0] MSG_BASE  = 8'd0,
    parameter logic [7:0] CT_BASE   = 8'd64,
    parameter int         FRAME_LEN = 64
) (
    input  logic       clk,
    input  logic       init,
    input  logic       start,
    input  logic [2:0] tap_sel,
    input  logic [5:0] seed,
    input  logic [5:0] msg_len,
    input  logic [7:0] rdata,
    output logic [7:0] raddr,
    output logic [7:0] waddr,
    output logic [7:0] wdata,
    output logic       wr_en,
    output logic       busy,
    output logic       done
);

    localparam logic [6:0] MAX_LEN = 7'(FRAME_LEN - PRE_LEN);
    localparam logic [6:0] PRE_K   = 7'(PRE_LEN);
    localparam logic [5:0] LAST_K  = 6'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [5:0] k;
    logic [5:0] lfsr;
    logic [5:0] taps;
    logic [6:0] len;
    logic [6:0] rel;
    logic [7:0] plain;
    logic       accept;
    logic [5:0] seed_eff;
    logic [6:0] len_eff;
    logic [5:0] lfsr_next;

    function automatic logic [5:0] tap_lookup(input logic [2:0] sel);
        logic [5:0] t;
        case (sel)
            3'd1:    t = 6'h2D;
            3'd2:    t = 6'h30;
            3'd3:    t = 6'h33;
            3'd4:    t = 6'h36;
            3'd5:    t = 6'h39;
            default: t = 6'h21;
        endcase
        return t;
    endfunction

    // A new frame may be started from IDLE or DONE; requests during WRITE are dropped.
    assign accept    = start && (state != WRITE);
    assign seed_eff  = (seed == 6'd0) ? 6'h01 : seed;
    assign len_eff   = ({1'b0, msg_len} > MAX_LEN) ? MAX_LEN : {1'b0, msg_len};
    assign lfsr_next = {lfsr[4:0], ^(lfsr & taps)};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = WRITE;
            WRITE:   if (k == LAST_K) state_next = DONE;
            DONE:    if (start) state_next = WRITE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state <= IDLE;
            k     <= 6'd0;
            lfsr  <= 6'h01;
            taps  <= 6'h21;
            len   <= 7'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                k    <= 6'd0;
                lfsr <= seed_eff;
                taps <= tap_lookup(tap_sel);
                len  <= len_eff;
            end else if (state == WRITE) begin
                k    <= k + 6'd1;
                lfsr <= lfsr_next;
            end
        end
    end

    // Outputs decode straight from state so an asserted init silences the write port at once.
    always_comb begin
        busy  = (state == WRITE);
        done  = (state == DONE);
        wr_en = (state == WRITE);
        raddr = MSG_BASE;
        waddr = CT_BASE + {2'b00, k};
        wdata = 8'h00;
        plain = 8'h20;
        rel   = {1'b0, k} - PRE_K;
        if ({1'b0, k} < PRE_K) begin
            plain = 8'h5F;
        end else if (rel < len) begin
            plain = rdata;
            if (state == WRITE) raddr = MSG_BASE + {1'b0, rel};
        end
        if (state == WRITE) wdata = plain ^ {2'b00, lfsr};
    end

endmodule
